// File: rtl/sigmoid_plan_pipe.sv
// -----------------------------------------------------------------------------
// sigmoid_plan_pipe
//
// Fully pipelined PLAN piecewise-linear approximation of y = 1/(1+e^-x).
// Signed fixed-point x (IN_W bits, IN_FRAC fractional) in, unsigned Q0.OUT_W
// y out. Three registered stages with valid/ready backpressure:
//   S1  magnitude |x|, sign, region decode
//   S2  positive-half value yp = C + (|x| >> k), exact, OUT_W+1 bits wide
//   S3  mirror for negative x (2^OUT_W - yp) or clip to all-ones for x >= 0
// Negative inputs are produced by exact mirroring, so y(x)+y(-x) = 2^OUT_W
// wherever the positive half does not clip.
//
// Optional feature macro: SIGMOID_SAT_CNT_EN
//   When defined, adds o_sat (sample came from the saturated region, registered
//   alongside o_y) and o_sat_cnt (saturating 16-bit count of saturated samples
//   transferred at the output). When undefined the datapath is identical and
//   neither port exists.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous reset, active-high
//   i_in_valid   in   1      input sample valid
//   o_in_ready   out  1      block accepts i_x this cycle (combinational)
//   i_x          in   IN_W   signed input sample
//   o_out_valid  out  1      o_y valid
//   i_out_ready  in   1      downstream accepts o_y
//   o_y          out  OUT_W  sigmoid result, unsigned Q0.OUT_W
//   o_sat        out  1      (SIGMOID_SAT_CNT_EN) sample was saturated
//   o_sat_cnt    out  16     (SIGMOID_SAT_CNT_EN) saturated-sample count
// -----------------------------------------------------------------------------
module sigmoid_plan_pipe #(
   parameter int IN_W    = 8,
   parameter int IN_FRAC = 5,
   parameter int OUT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [IN_W-1:0]  i_x,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [OUT_W-1:0] o_y
`ifdef SIGMOID_SAT_CNT_EN
   ,
   output logic             o_sat,
   output logic [15:0]      o_sat_cnt
`endif
);

   // Widths: YW holds yp including the 1.0 bit; MW holds |x| aligned to the
   // output binary point; CW holds 8*|x| for exact threshold comparisons.
   localparam int SH = OUT_W - IN_FRAC;
   localparam int MW = IN_W + SH;
   localparam int YW = OUT_W + 1;
   localparam int CW = IN_W + 8;

   // Region thresholds expressed as 8*threshold in input LSBs so that the
   // 2.375 boundary (19/8) stays an integer for any IN_FRAC.
   localparam logic [CW-1:0] T_R1 = CW'(32'd8)  << IN_FRAC;  // 1.0
   localparam logic [CW-1:0] T_R2 = CW'(32'd19) << IN_FRAC;  // 2.375
   localparam logic [CW-1:0] T_R3 = CW'(32'd40) << IN_FRAC;  // 5.0

   // Segment offsets in Q1.OUT_W.
   localparam logic [YW-1:0] C_R0  = YW'(32'd1)  << (OUT_W - 1);  // 0.5
   localparam logic [YW-1:0] C_R1  = YW'(32'd5)  << (OUT_W - 3);  // 0.625
   localparam logic [YW-1:0] C_R2  = YW'(32'd27) << (OUT_W - 5);  // 0.84375
   localparam logic [YW-1:0] Y_ONE = YW'(32'd1)  << OUT_W;        // 1.0

   localparam logic [1:0] REG_R0 = 2'd0;
   localparam logic [1:0] REG_R1 = 2'd1;
   localparam logic [1:0] REG_R2 = 2'd2;
   localparam logic [1:0] REG_R3 = 2'd3;

   // Reject parameter sets the exact datapath cannot represent.
   if ((OUT_W < IN_FRAC + 5) || (IN_W <= IN_FRAC + 1)) begin : g_param_check
      $error("sigmoid_plan_pipe: illegal parameters (need OUT_W >= IN_FRAC+5 and IN_W > IN_FRAC+1)");
   end

   // ------------------------------------------------------------------
   // Stage registers
   // ------------------------------------------------------------------
   logic             s1_valid_r;
   logic [IN_W-1:0]  s1_mag_r;
   logic             s1_sign_r;
   logic [1:0]       s1_region_r;

   logic             s2_valid_r;
   logic [YW-1:0]    s2_yp_r;
   logic             s2_sign_r;

   logic             s3_valid_r;
   logic [OUT_W-1:0] s3_y_r;

   // ------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------
   logic             s1_en_s;
   logic             s2_en_s;
   logic             s3_en_s;
   logic [IN_W-1:0]  mag_s;
   logic [CW-1:0]    mag8_s;
   logic [1:0]       region_s;
   logic [MW-1:0]    mag_full_s;
   logic [YW-1:0]    yp_s;
   logic [OUT_W-1:0] y_s;

   // Ready chain: a stage may load when empty or when its content moves on.
   always_comb begin
      s3_en_s    = !s3_valid_r || i_out_ready;
      s2_en_s    = !s2_valid_r || s3_en_s;
      s1_en_s    = !s1_valid_r || s2_en_s;
      o_in_ready = s1_en_s && !rst;
   end

   // S1 datapath: unsigned magnitude (exact for the most negative code) and
   // region decode against the scaled thresholds.
   always_comb begin
      mag_s    = i_x;
      mag8_s   = {CW{1'b0}};
      region_s = REG_R0;
      if (i_x[IN_W-1]) begin
         mag_s = IN_W'(32'd0) - i_x;
      end else begin
         mag_s = i_x;
      end
      mag8_s = CW'({mag_s, 3'b000});
      if (mag8_s < T_R1) begin
         region_s = REG_R0;
      end else if (mag8_s < T_R2) begin
         region_s = REG_R1;
      end else if (mag8_s < T_R3) begin
         region_s = REG_R2;
      end else begin
         region_s = REG_R3;
      end
   end

   // S2 datapath: positive-half value. The slope shift never drops set bits
   // because M carries at least five zero LSBs.
   always_comb begin
      mag_full_s = MW'(s1_mag_r) << SH;
      yp_s       = Y_ONE;
      case (s1_region_r)
         REG_R0:  yp_s = C_R0 + YW'(mag_full_s >> 2);
         REG_R1:  yp_s = C_R1 + YW'(mag_full_s >> 3);
         REG_R2:  yp_s = C_R2 + YW'(mag_full_s >> 5);
         REG_R3:  yp_s = Y_ONE;
         default: yp_s = Y_ONE;
      endcase
   end

   // S3 datapath: mirror negative inputs exactly; clip 1.0 to all-ones on
   // the positive side since Q0.OUT_W cannot hold 1.0.
   always_comb begin
      y_s = {OUT_W{1'b0}};
      if (s2_sign_r) begin
         y_s = OUT_W'(Y_ONE - s2_yp_r);
      end else if (s2_yp_r[OUT_W]) begin
         y_s = {OUT_W{1'b1}};
      end else begin
         y_s = s2_yp_r[OUT_W-1:0];
      end
   end

   // Pipeline registers: each stage loads from its predecessor when enabled,
   // otherwise holds. Data only captured alongside a valid sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         s1_mag_r    <= {IN_W{1'b0}};
         s1_sign_r   <= 1'b0;
         s1_region_r <= REG_R0;
         s2_valid_r  <= 1'b0;
         s2_yp_r     <= {YW{1'b0}};
         s2_sign_r   <= 1'b0;
         s3_valid_r  <= 1'b0;
         s3_y_r      <= {OUT_W{1'b0}};
      end else begin
         if (s1_en_s) begin
            s1_valid_r <= i_in_valid;
            if (i_in_valid) begin
               s1_mag_r    <= mag_s;
               s1_sign_r   <= i_x[IN_W-1];
               s1_region_r <= region_s;
            end
         end
         if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
               s2_yp_r   <= yp_s;
               s2_sign_r <= s1_sign_r;
            end
         end
         if (s3_en_s) begin
            s3_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
               s3_y_r <= y_s;
            end
         end
      end
   end

   assign o_out_valid = s3_valid_r;
   assign o_y         = s3_y_r;

`ifdef SIGMOID_SAT_CNT_EN
   logic        s2_sat_r;
   logic        s3_sat_r;
   logic [15:0] sat_cnt_r;

   // Saturation flag travels with its sample through S2 and S3.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_sat_r <= 1'b0;
         s3_sat_r <= 1'b0;
      end else begin
         if (s2_en_s && s1_valid_r) begin
            s2_sat_r <= (s1_region_r == REG_R3);
         end
         if (s3_en_s && s2_valid_r) begin
            s3_sat_r <= s2_sat_r;
         end
      end
   end

   // Saturating count of saturated samples, counted at output transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_cnt_r <= 16'h0000;
      end else if (s3_valid_r && i_out_ready && s3_sat_r && (sat_cnt_r != 16'hFFFF)) begin
         sat_cnt_r <= sat_cnt_r + 16'h0001;
      end else begin
         sat_cnt_r <= sat_cnt_r;
      end
   end

   assign o_sat     = s3_sat_r;
   assign o_sat_cnt = sat_cnt_r;
`endif

endmodule

// File: tb/tb_sigmoid_plan_pipe.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_plan_pipe
//
// Self-checking bench for sigmoid_plan_pipe. Two instances: the default
// 8-bit configuration for handshake, latency and randomized streaming, and a
// 10-bit-input configuration that can reach the saturated region. Expected
// results come from a real-valued model of the piecewise-linear sigmoid and
// a queue of accepted-but-not-emitted samples.
// -----------------------------------------------------------------------------
module tb_sigmoid_plan_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [7:0]  i_x;
   logic        o_out_valid;
   logic        i_out_ready;
   logic [15:0] o_y;

   logic        in_valid10;
   logic        in_ready10;
   logic [9:0]  x10;
   logic        out_valid10;
   logic        out_ready10;
   logic [15:0] y10;
`ifdef SIGMOID_SAT_CNT_EN
   logic        sat8;
   logic [15:0] sat_cnt8;
   logic        sat10;
   logic [15:0] sat_cnt10;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   int   exp_q[$];
   logic held;
   logic [15:0] held_y;
   logic obs_valid;
   logic [15:0] obs_y;

   always #5 clk = ~clk;

   sigmoid_plan_pipe #(.IN_W(8), .IN_FRAC(5), .OUT_W(16)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_x         (i_x),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_y         (o_y)
`ifdef SIGMOID_SAT_CNT_EN
      ,
      .o_sat       (sat8),
      .o_sat_cnt   (sat_cnt8)
`endif
   );

   sigmoid_plan_pipe #(.IN_W(10), .IN_FRAC(5), .OUT_W(16)) u_dut10 (
      .clk         (clk),
      .rst         (rst),
      .i_in_valid  (in_valid10),
      .o_in_ready  (in_ready10),
      .i_x         (x10),
      .o_out_valid (out_valid10),
      .i_out_ready (out_ready10),
      .o_y         (y10)
`ifdef SIGMOID_SAT_CNT_EN
      ,
      .o_sat       (sat10),
      .o_sat_cnt   (sat_cnt10)
`endif
   );

   // Count one comparison and report it when it does not hold.
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference sigmoid: segments evaluated on the real value of x.
   function automatic int ref_sigmoid(input int raw, input int in_w, input int in_frac, input int out_w);
      int  xs;
      real a;
      real yp;
      real full;
      real res;
      xs = raw;
      if (raw >= (1 << (in_w - 1))) xs = raw - (1 << in_w);
      a = ((xs < 0) ? -xs : xs) / (2.0 ** in_frac);
      if (a < 1.0)        yp = 0.5 + a / 4.0;
      else if (a < 2.375) yp = 0.625 + a / 8.0;
      else if (a < 5.0)   yp = 0.84375 + a / 32.0;
      else                yp = 1.0;
      full = 2.0 ** out_w;
      if (xs < 0) res = full - yp * full;
      else if (yp * full > full - 1.0) res = full - 1.0;
      else res = yp * full;
      return int'(res);
   endfunction

   // One cycle on the 8-bit instance: drive inputs, check handshake and
   // scoreboard, then advance to just after the next rising edge.
   task automatic drive_cycle(input logic v, input logic [7:0] x, input logic rdy);
      i_in_valid  = v;
      i_x         = x;
      i_out_ready = rdy;
      #1;
      obs_valid = o_out_valid;
      obs_y     = o_y;
      check_val("in_ready", {31'd0, o_in_ready}, {31'd0, (exp_q.size() < 3) || rdy});
      if (held) begin
         check_val("stall_valid", {31'd0, o_out_valid}, 32'd1);
         check_val("stall_y", {16'd0, o_y}, {16'd0, held_y});
      end
      if (o_out_valid && rdy) begin
         if (exp_q.size() == 0) begin
            check_val("spurious_out", 32'd1, 32'd0);
         end else begin
            check_val("y", {16'd0, o_y}, exp_q.pop_front());
         end
      end
      if (v && o_in_ready) exp_q.push_back(ref_sigmoid(int'(x), 8, 5, 16));
      held   = o_out_valid && !rdy;
      held_y = o_y;
      @(posedge clk);
      #1;
   endtask

   logic [7:0]  stream_x [5];
   logic [15:0] stream_y [5];
   logic [9:0]  seq10 [4];
   logic [15:0] exp10 [4];
   logic [15:0] got10 [4];
   logic        gsat10 [4];
   int          n10;

   initial begin
      stream_x = '{8'h20, 8'hE0, 8'h4C, 8'h7F, 8'h80};
      stream_y = '{16'hC000, 16'h4000, 16'hEB00, 16'hF7C0, 16'h0800};
      seq10    = '{10'h0A0, 10'h360, 10'h1FF, 10'h000};
      exp10    = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h8000};
      held = 1'b0;
      rst = 1'b1;
      i_in_valid = 1'b0; i_x = 8'h00; i_out_ready = 1'b1;
      in_valid10 = 1'b0; x10 = 10'h000; out_ready10 = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      i_in_valid = 1'b1;
      #1;
      check_val("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
      check_val("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
      check_val("rst_y", {16'd0, o_y}, 32'd0);
      i_in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Latency: x=0 gives exactly 0.5 three cycles later, one-cycle pulse.
      drive_cycle(1'b1, 8'h00, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         drive_cycle(1'b0, 8'h00, 1'b1);
         check_val($sformatf("lat_valid_c%0d", c), {31'd0, obs_valid}, {31'd0, c == 3});
         if (c == 3) check_val("lat_y_zero", {16'd0, obs_y}, 32'h8000);
      end

      // Back-to-back stream, outputs on consecutive cycles.
      for (int c = 0; c < 8; c++) begin
         drive_cycle(c < 5, stream_x[(c < 5) ? c : 0], 1'b1);
         if (c >= 3) begin
            check_val($sformatf("stream_valid_%0d", c - 3), {31'd0, obs_valid}, 32'd1);
            check_val($sformatf("stream_y_%0d", c - 3), {16'd0, obs_y}, {16'd0, stream_y[c - 3]});
         end
      end

      // Stall for 6 cycles mid-stream, then release.
      for (int c = 0; c < 16; c++) begin
         drive_cycle(c < 10, 8'(8'h10 + 8'(c * 7)), !(c >= 4 && c < 10));
      end
      check_val("stall_drain", exp_q.size(), 32'd0);

      // Reset with three samples in flight: none may emerge.
      for (int c = 0; c < 3; c++) drive_cycle(1'b1, 8'(8'h30 + 8'(c)), 1'b0);
      rst = 1'b1;
      i_in_valid = 1'b1;
      i_out_ready = 1'b1;
      #1;
      check_val("midrst_in_ready", {31'd0, o_in_ready}, 32'd0);
      @(posedge clk); #1;
      check_val("midrst_out_valid", {31'd0, o_out_valid}, 32'd0);
      check_val("midrst_y", {16'd0, o_y}, 32'd0);
      exp_q.delete();
      held = 1'b0;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) drive_cycle(1'b0, 8'h00, 1'b1);

      // 10-bit instance: saturation on both sides and the out-of-table code.
      n10 = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid10 && n10 < 4) begin
            got10[n10] = y10;
`ifdef SIGMOID_SAT_CNT_EN
            gsat10[n10] = sat10;
`else
            gsat10[n10] = 1'b0;
`endif
            n10++;
         end
         in_valid10 = (c < 4);
         x10 = seq10[(c < 4) ? c : 0];
         @(posedge clk); #1;
      end
      in_valid10 = 1'b0;
      check_val("w10_count", n10, 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < n10) begin
            check_val($sformatf("w10_y_%0d", k), {16'd0, got10[k]}, {16'd0, exp10[k]});
            check_val($sformatf("w10_model_%0d", k), {16'd0, got10[k]},
                      ref_sigmoid(int'(seq10[k]), 10, 5, 16));
`ifdef SIGMOID_SAT_CNT_EN
            check_val($sformatf("w10_sat_%0d", k), {31'd0, gsat10[k]}, {31'd0, k < 3});
`endif
         end
      end
`ifdef SIGMOID_SAT_CNT_EN
      check_val("w10_sat_cnt", {16'd0, sat_cnt10}, 32'd3);
      check_val("w8_sat_cnt", {16'd0, sat_cnt8}, 32'd0);
`endif

      // Randomized stream with random backpressure.
      for (int c = 0; c < 600; c++) begin
         drive_cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6);
      end
      for (int c = 0; c < 20; c++) begin
         if (exp_q.size() > 0) drive_cycle(1'b0, 8'h00, 1'b1);
      end
      check_val("rand_drain", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
